// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU codes,
// FSM states and the per-state control word.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b101;

  typedef enum logic [4:0] {
    S_IF     = 5'd0,
    S_ID     = 5'd1,
    S_EX_R   = 5'd2,
    S_EX_MEM = 5'd3,
    S_MEM_RD = 5'd4,
    S_MEM_WR = 5'd5,
    S_WB_LW  = 5'd6,
    S_WB_R   = 5'd7,
    S_EX_I   = 5'd8,
    S_WB_I   = 5'd9,
    S_EX_LUI = 5'd10,
    S_EX_BEQ = 5'd11,
    S_EX_BNE = 5'd12,
    S_EX_J   = 5'd13,
    S_EX_JAL = 5'd14,
    S_EX_JR  = 5'd15,
    S_ERR    = 5'd16
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO  = 3'd0,
    CLS_ADD   = 3'd1,
    CLS_RTYPE = 3'd2,
    CLS_IMM   = 3'd3,
    CLS_SUB   = 3'd4
  } alu_cls_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
  } ctl_t;

  function automatic ctl_t ctl_decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_IF:     begin c.mem_read = 1'b1; c.fetch = 1'b1; c.alu_src_b = 2'b01; end
      S_ID:     c.alu_src_b = 2'b11;
      S_EX_R:   c.alu_src_a = 1'b1;
      S_EX_MEM,
      S_EX_I:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_RD: begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEM_WR: begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_WB_LW:  begin c.mem_to_reg = 2'b01; c.reg_write = 1'b1; end
      S_WB_R:   begin c.reg_dst = 2'b01; c.reg_write = 1'b1; end
      S_WB_I:   c.reg_write = 1'b1;
      S_EX_LUI: begin c.mem_to_reg = 2'b11; c.reg_write = 1'b1; end
      S_EX_BEQ,
      S_EX_BNE: begin
        c.alu_src_a     = 1'b1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.branch        = (s == S_EX_BEQ);
      end
      S_EX_J:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_EX_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
        c.reg_dst    = 2'b10;
        c.mem_to_reg = 2'b10;
        c.reg_write  = 1'b1;
      end
      S_EX_JR:  begin c.pc_write = 1'b1; c.pc_source = 2'b11; end
      default:  ;
    endcase
    return c;
  endfunction

  function automatic alu_cls_t alu_cls_of(input state_t s);
    case (s)
      S_IF, S_ID, S_EX_MEM: return CLS_ADD;
      S_EX_R:               return CLS_RTYPE;
      S_EX_I:               return CLS_IMM;
      S_EX_BEQ, S_EX_BNE:   return CLS_SUB;
      default:              return CLS_ZERO;
    endcase
  endfunction

  function automatic state_t id_next(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE:                          return (fn == FN_JR) ? S_EX_JR : S_EX_R;
      OP_LW, OP_SW:                      return S_EX_MEM;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_EX_I;
      OP_LUI:                            return S_EX_LUI;
      OP_BEQ:                            return S_EX_BEQ;
      OP_BNE:                            return S_EX_BNE;
      OP_J:                              return S_EX_J;
      OP_JAL:                            return S_EX_JAL;
      default:                           return S_ERR;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decode from the state class and the instruction opcode/funct fields.
import mc_pkg::*;

module mc_alu_dec (
  input  logic [2:0] cls,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  output logic [2:0] alu_ctl
);

  always_comb begin
    alu_ctl = ALU_AND;
    case (alu_cls_t'(cls))
      CLS_ADD: alu_ctl = ALU_ADD;
      CLS_SUB: alu_ctl = ALU_SUB;
      CLS_RTYPE: begin
        case (Fun)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          FN_NOR:  alu_ctl = ALU_NOR;
          FN_XOR:  alu_ctl = ALU_XOR;
          FN_SRL:  alu_ctl = ALU_SRL;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      CLS_IMM: begin
        case (OPcode)
          OP_ANDI: alu_ctl = ALU_AND;
          OP_ORI:  alu_ctl = ALU_OR;
          OP_SLTI: alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready stalls.
// MC_ILLEGAL_TRAP_EN: when defined, ERR is sticky until reset and raises illegal.
import mc_pkg::*;

module mc_ctrl #(
  parameter int unsigned STATE_W       = 5,
  parameter bit          INIT_PC_WRITE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         OPcode,
  input  logic [5:0]         Fun,
  input  logic               zero,
  input  logic               MIO_ready,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic [1:0]         PCSource,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALU_Control,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               CPU_MIO,
  output logic [STATE_W-1:0] state_out,
  output logic               illegal
);

  state_t     state_q, state_d;
  ctl_t       ctl_q, ctl_d;
  logic [2:0] alu_q, alu_d;
  logic [2:0] cls_d;
  logic       first_fetch_q;
  logic       fetch_go;
  logic       unused_zero;

  // Branch resolution uses zero inside the datapath, not here.
  assign unused_zero = zero;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:     if (MIO_ready) state_d = S_ID;
      S_ID:     state_d = id_next(OPcode, Fun);
      S_EX_R:   state_d = S_WB_R;
      S_EX_MEM: state_d = (OPcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (MIO_ready) state_d = S_WB_LW;
      S_MEM_WR: if (MIO_ready) state_d = S_IF;
      S_EX_I:   state_d = S_WB_I;
`ifdef MC_ILLEGAL_TRAP_EN
      S_ERR:    state_d = S_ERR;
`else
      S_ERR:    state_d = S_IF;
`endif
      default:  state_d = S_IF;
    endcase
  end

  // Outputs are registered by decoding the next state alongside the state update.
  assign ctl_d = ctl_decode(state_d);
  assign cls_d = alu_cls_of(state_d);

  mc_alu_dec u_alu_dec (
    .cls     (cls_d),
    .OPcode  (OPcode),
    .Fun     (Fun),
    .alu_ctl (alu_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IF;
      ctl_q         <= ctl_decode(S_IF);
      alu_q         <= ALU_ADD;
      first_fetch_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      alu_q   <= alu_d;
      if (state_q == S_IF && MIO_ready) first_fetch_q <= 1'b0;
    end
  end

  // Fetch strobes follow MIO_ready directly; all write strobes are masked while in reset.
  assign fetch_go    = rst & ctl_q.fetch & MIO_ready;
  assign IRWrite     = fetch_go;
  assign PCWrite     = rst & (ctl_q.pc_write |
                              (fetch_go & (INIT_PC_WRITE | ~first_fetch_q)));
  assign MemRead     = rst & ctl_q.mem_read;
  assign MemWrite    = rst & ctl_q.mem_write;
  assign RegWrite    = rst & ctl_q.reg_write;
  assign CPU_MIO     = MemRead | MemWrite;
  assign IorD        = ctl_q.iord;
  assign PCWriteCond = ctl_q.pc_write_cond;
  assign Branch      = ctl_q.branch;
  assign PCSource    = ctl_q.pc_source;
  assign ALUSrcA     = ctl_q.alu_src_a;
  assign ALUSrcB     = ctl_q.alu_src_b;
  assign ALU_Control = alu_q;
  assign RegDst      = ctl_q.reg_dst;
  assign MemtoReg    = ctl_q.mem_to_reg;
  assign state_out   = STATE_W'(state_q);

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_ERR);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed table, hand-written corner sequences and
// random instruction streams against a per-instruction micro-step model.
module tb_mc_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] OPcode = 6'b000000;
  logic [5:0] Fun = 6'b100000;
  logic       zero = 1'b0;
  logic       MIO_ready = 1'b0;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, Branch;
  logic [1:0] PCSource, ALUSrcB, RegDst, MemtoReg;
  logic       ALUSrcA, RegWrite, CPU_MIO, illegal;
  logic [2:0] ALU_Control;
  logic [4:0] state_out;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.STATE_W(5), .INIT_PC_WRITE(1'b1)) dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .zero(zero), .MIO_ready(MIO_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .PCSource(PCSource),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .CPU_MIO(CPU_MIO), .state_out(state_out),
    .illegal(illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: an instruction expands into a list of micro-steps with expected strobes.
  typedef struct {
    logic [4:0] st;
    logic rd, wr, io, irw, pcw, rw;
    logic [2:0] alu;
    logic rdy;
  } step_t;
  step_t plan[$];

  function automatic step_t mk(input state_t s, input logic rd, wr, io, irw, pcw, rw,
                               input logic [2:0] alu, input logic rdy);
    step_t t;
    t.st = s; t.rd = rd; t.wr = wr; t.io = io; t.irw = irw; t.pcw = pcw; t.rw = rw;
    t.alu = alu; t.rdy = rdy;
    return t;
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      6'b100111: return 3'b100;
      6'b100110: return 3'b011;
      6'b000010: return 3'b101;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b000;
      6'b001101: return 3'b001;
      6'b001010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input int unsigned k_if, input int unsigned k_mem);
    plan.delete();
    for (int i = 0; i < int'(k_if); i++) plan.push_back(mk(S_IF, 1, 0, 0, 0, 0, 0, 3'b010, 0));
    plan.push_back(mk(S_IF, 1, 0, 0, 1, 1, 0, 3'b010, 1));
    plan.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 3'b010, rnd()));
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) plan.push_back(mk(S_EX_JR, 0, 0, 0, 0, 1, 0, 3'b000, rnd()));
        else begin
          plan.push_back(mk(S_EX_R, 0, 0, 0, 0, 0, 0, r_alu(fn), rnd()));
          plan.push_back(mk(S_WB_R, 0, 0, 0, 0, 0, 1, 3'b000, rnd()));
        end
      end
      6'b100011: begin
        plan.push_back(mk(S_EX_MEM, 0, 0, 0, 0, 0, 0, 3'b010, rnd()));
        for (int i = 0; i < int'(k_mem); i++) plan.push_back(mk(S_MEM_RD, 1, 0, 1, 0, 0, 0, 3'b000, 0));
        plan.push_back(mk(S_MEM_RD, 1, 0, 1, 0, 0, 0, 3'b000, 1));
        plan.push_back(mk(S_WB_LW, 0, 0, 0, 0, 0, 1, 3'b000, rnd()));
      end
      6'b101011: begin
        plan.push_back(mk(S_EX_MEM, 0, 0, 0, 0, 0, 0, 3'b010, rnd()));
        for (int i = 0; i < int'(k_mem); i++) plan.push_back(mk(S_MEM_WR, 0, 1, 1, 0, 0, 0, 3'b000, 0));
        plan.push_back(mk(S_MEM_WR, 0, 1, 1, 0, 0, 0, 3'b000, 1));
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        plan.push_back(mk(S_EX_I, 0, 0, 0, 0, 0, 0, i_alu(op), rnd()));
        plan.push_back(mk(S_WB_I, 0, 0, 0, 0, 0, 1, 3'b000, rnd()));
      end
      6'b001111: plan.push_back(mk(S_EX_LUI, 0, 0, 0, 0, 0, 1, 3'b000, rnd()));
      6'b000100: plan.push_back(mk(S_EX_BEQ, 0, 0, 0, 0, 0, 0, 3'b110, rnd()));
      6'b000101: plan.push_back(mk(S_EX_BNE, 0, 0, 0, 0, 0, 0, 3'b110, rnd()));
      6'b000010: plan.push_back(mk(S_EX_J, 0, 0, 0, 0, 1, 0, 3'b000, rnd()));
      6'b000011: plan.push_back(mk(S_EX_JAL, 0, 0, 0, 0, 1, 1, 3'b000, rnd()));
      default:   plan.push_back(mk(S_ERR, 0, 0, 0, 0, 0, 0, 3'b000, rnd()));
    endcase
  endtask

  task automatic run_plan(input string tag);
    for (int i = 0; i < plan.size(); i++) begin
      MIO_ready = plan[i].rdy;
      zero = rnd();
      #1;
      chk(tag, {state_out, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, CPU_MIO, ALU_Control},
          {plan[i].st, plan[i].rd, plan[i].wr, plan[i].io, plan[i].irw, plan[i].pcw, plan[i].rw,
           plan[i].rd | plan[i].wr, plan[i].alu});
      tick();
    end
    chk({tag, " end"}, state_out, S_IF);
  endtask

  // Directed table: instruction -> execute state, its ALU op, total cycles with MIO_ready=1.
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] ex;
    logic [2:0] alu;
    int         len;
  } vec_t;

  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    OPcode = op; Fun = fn; MIO_ready = 1'b1;
    tick();
  endtask

  initial begin
    vec_t vt[$];
    logic [5:0] ops[$];
    int n;

    vt.push_back('{"add",   6'b000000, 6'b100000, S_EX_R,   3'b010, 4});
    vt.push_back('{"sub",   6'b000000, 6'b100010, S_EX_R,   3'b110, 4});
    vt.push_back('{"and",   6'b000000, 6'b100100, S_EX_R,   3'b000, 4});
    vt.push_back('{"or",    6'b000000, 6'b100101, S_EX_R,   3'b001, 4});
    vt.push_back('{"slt",   6'b000000, 6'b101010, S_EX_R,   3'b111, 4});
    vt.push_back('{"nor",   6'b000000, 6'b100111, S_EX_R,   3'b100, 4});
    vt.push_back('{"xor",   6'b000000, 6'b100110, S_EX_R,   3'b011, 4});
    vt.push_back('{"srl",   6'b000000, 6'b000010, S_EX_R,   3'b101, 4});
    vt.push_back('{"rfunx", 6'b000000, 6'b111111, S_EX_R,   3'b010, 4});
    vt.push_back('{"jr",    6'b000000, 6'b001000, S_EX_JR,  3'b000, 3});
    vt.push_back('{"lw",    6'b100011, 6'b000000, S_EX_MEM, 3'b010, 5});
    vt.push_back('{"sw",    6'b101011, 6'b000000, S_EX_MEM, 3'b010, 4});
    vt.push_back('{"addi",  6'b001000, 6'b000000, S_EX_I,   3'b010, 4});
    vt.push_back('{"andi",  6'b001100, 6'b000000, S_EX_I,   3'b000, 4});
    vt.push_back('{"ori",   6'b001101, 6'b000000, S_EX_I,   3'b001, 4});
    vt.push_back('{"slti",  6'b001010, 6'b000000, S_EX_I,   3'b111, 4});
    vt.push_back('{"lui",   6'b001111, 6'b000000, S_EX_LUI, 3'b000, 3});
    vt.push_back('{"beq",   6'b000100, 6'b000000, S_EX_BEQ, 3'b110, 3});
    vt.push_back('{"bne",   6'b000101, 6'b000000, S_EX_BNE, 3'b110, 3});
    vt.push_back('{"j",     6'b000010, 6'b000000, S_EX_J,   3'b000, 3});
    vt.push_back('{"jal",   6'b000011, 6'b000000, S_EX_JAL, 3'b000, 3});
`ifndef MC_ILLEGAL_TRAP_EN
    vt.push_back('{"ill",   6'b111111, 6'b000000, S_ERR,    3'b000, 3});
`endif

    // Reset held: strobes forced low, other outputs at their fetch values.
    repeat (2) tick();
    chk("rst state", state_out, S_IF);
    chk("rst strobes", {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, CPU_MIO, illegal}, 7'b0);
    chk("rst fetch sel", {IorD, ALUSrcA, ALUSrcB, PCSource, ALU_Control}, {1'b0, 1'b0, 2'b01, 2'b00, 3'b010});
    rst = 1'b1;
    OPcode = 6'b000000; Fun = 6'b100000;
    for (int i = 0; i < 3; i++) begin
      MIO_ready = 1'b0; #1;
      chk("stall if", {state_out, PCWrite, IRWrite, MemRead}, {5'(S_IF), 1'b0, 1'b0, 1'b1});
      tick();
    end
    MIO_ready = 1'b1; #1;
    chk("fetch go", {state_out, IRWrite, PCWrite}, {5'(S_IF), 1'b1, 1'b1});
    tick();
    chk("add id", state_out, S_ID);
    tick();
    chk("add ex", {state_out, ALU_Control, RegWrite, ALUSrcA, ALUSrcB}, {5'(S_EX_R), 3'b010, 1'b0, 1'b1, 2'b00});
    tick();
    chk("add wb", {state_out, RegWrite, RegDst, MemtoReg}, {5'(S_WB_R), 1'b1, 2'b01, 2'b00});
    tick();
    chk("add done", {state_out, RegWrite}, {5'(S_IF), 1'b0});

    // Directed table with MIO_ready held high.
    foreach (vt[k]) begin
      fetch(vt[k].op, vt[k].fn);
      tick();
      chk({vt[k].name, " ex"}, {state_out, ALU_Control}, {vt[k].ex, vt[k].alu});
      n = 2;
      while (state_out != S_IF && n < 12) begin tick(); n++; end
      chk({vt[k].name, " len"}, n, vt[k].len);
    end

    // lw with MEM_RD stalled two cycles.
    fetch(6'b100011, 6'b000000);
    tick(); tick();
    MIO_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) MIO_ready = 1'b1;
      #1;
      chk("lw memrd", {state_out, IorD, MemRead, CPU_MIO}, {5'(S_MEM_RD), 1'b1, 1'b1, 1'b1});
      tick();
    end
    chk("lw wb", {state_out, MemtoReg, RegWrite, RegDst}, {5'(S_WB_LW), 2'b01, 1'b1, 2'b00});
    tick();

    // beq then bne, both with zero=1.
    zero = 1'b1;
    fetch(6'b000100, 6'b000000); tick();
    chk("beq", {state_out, PCWriteCond, Branch, ALU_Control, PCSource, PCWrite},
        {5'(S_EX_BEQ), 1'b1, 1'b1, 3'b110, 2'b01, 1'b0});
    tick();
    fetch(6'b000101, 6'b000000); tick();
    chk("bne", {state_out, PCWriteCond, Branch, ALU_Control}, {5'(S_EX_BNE), 1'b1, 1'b0, 3'b110});
    tick();

    fetch(6'b000011, 6'b000000); tick();
    chk("jal", {state_out, PCWrite, PCSource, RegDst, MemtoReg, RegWrite},
        {5'(S_EX_JAL), 1'b1, 2'b10, 2'b10, 2'b10, 1'b1});
    tick();

    // Reset during a stalled store must drop the write strobe at once.
    fetch(6'b101011, 6'b000000); tick(); tick();
    MIO_ready = 1'b0; #1;
    chk("sw hold", {state_out, MemWrite}, {5'(S_MEM_WR), 1'b1});
    rst = 1'b0; #1;
    chk("sw abort", {state_out, MemWrite, CPU_MIO, RegWrite}, {5'(S_IF), 1'b0, 1'b0, 1'b0});
    tick();
    rst = 1'b1;

    // Illegal opcode.
    fetch(6'b111111, 6'b000000); tick();
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk("err sticky", {state_out, illegal, PCWrite, RegWrite, MemWrite, MemRead},
          {5'(S_ERR), 1'b1, 4'b0});
      tick();
    end
    rst = 1'b0; #1;
    chk("err clear", {state_out, illegal}, {5'(S_IF), 1'b0});
    tick();
    rst = 1'b1;
`else
    chk("err nop", {state_out, illegal, PCWrite, RegWrite}, {5'(S_ERR), 1'b0, 1'b0, 1'b0});
    tick();
    chk("err ret", {state_out, illegal}, {5'(S_IF), 1'b0});
`endif

    // Random instruction stream with random stalls and noise on ignored inputs.
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100, 6'b001101,
            6'b001010, 6'b001111, 6'b000100, 6'b000101, 6'b000010, 6'b000011};
    for (int t = 0; t < 60; t++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, ops.size() - 1)];
      fn = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) fn = 6'b001000;
      OPcode = op; Fun = fn;
      build(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
      run_plan($sformatf("rnd%0d op%02h fn%02h", t, op, fn));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
